// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one variable-latency memory port between the fetch
//               stage (instruction reads) and the memory stage (loads and
//               stores). Data accesses win arbitration unless fetch has been
//               passed over STARVE_LIMIT times in a row. The winning request
//               is registered onto the port, held until mem_ready, and the
//               result is returned as a one-cycle valid pulse.
//
// Ports       : clk, rst        - rising-edge clock, async active-low reset
//               if_req/if_addr  - fetch request and address (held to if_valid)
//               if_flush        - redirect; squashes the pending fetch result
//               if_rdata        - fetched instruction (32 bits)
//               if_valid        - fetch response pulse
//               if_stall        - fetch waiting (combinational)
//               d_req/d_we/d_size/d_addr/d_wdata - data request fields
//               d_rdata         - load data (0 for stores)
//               d_valid         - data response pulse
//               d_stall         - data access waiting (combinational)
//               mem_req/mem_we/mem_size/mem_addr/mem_wdata - port request
//               mem_ready       - port completes the access this cycle
//               mem_rdata       - port read data, valid with mem_ready
//
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W       = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    // fetch stage
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [31:0]       if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    // memory stage
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [63:0]       d_wdata,
    output logic [63:0]       d_rdata,
    output logic              d_valid,
    output logic              d_stall,
    // shared memory port
    output logic              mem_req,
    output logic              mem_we,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [63:0]       mem_rdata
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_ISSUE_I = 3'd1;
    localparam logic [2:0] c_ISSUE_D = 3'd2;
    localparam logic [2:0] c_RESP_I  = 3'd3;
    localparam logic [2:0] c_RESP_D  = 3'd4;

    localparam logic [3:0] c_STARVE_LIMIT = 4'(STARVE_LIMIT);
    localparam logic [1:0] c_SIZE_WORD    = 2'b10;

    logic [2:0]        r_state;
    logic [2:0]        w_nextState;
    logic [3:0]        r_starveCnt;
    logic              r_kill;

    logic              w_grantD;
    logic              w_grantI;
    logic              w_fetchDone;
    logic              w_dataDone;
    logic              w_squashFetch;

    logic              r_memReq;
    logic              r_memWe;
    logic [1:0]        r_memSize;
    logic [ADDR_W-1:0] r_memAddr;
    logic [63:0]       r_memWdata;
    logic [31:0]       r_ifRdata;
    logic [63:0]       r_dRdata;
    logic              r_ifValid;
    logic              r_dValid;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // ------------------------------------------------------------------
    // Next state and arbitration. Arbitration happens only in IDLE, so a
    // requester can drop or change its request during its valid cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_nextState = r_state;
        w_grantD    = 1'b0;
        w_grantI    = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (d_req && (!if_req || (r_starveCnt < c_STARVE_LIMIT))) begin
                    w_grantD    = 1'b1;
                    w_nextState = c_ISSUE_D;
                end else if (if_req) begin
                    w_grantI    = 1'b1;
                    w_nextState = c_ISSUE_I;
                end
            end
            c_ISSUE_I: begin
                if (mem_ready) begin
                    w_nextState = c_RESP_I;
                end
            end
            c_ISSUE_D: begin
                if (mem_ready) begin
                    w_nextState = c_RESP_D;
                end
            end
            c_RESP_I,
            c_RESP_D: begin
                w_nextState = c_IDLE;
            end
            default: begin
                w_nextState = c_IDLE;
            end
        endcase
    end

    // mem_ready outside ISSUE is ignored by construction.
    assign w_fetchDone = (r_state == c_ISSUE_I) && mem_ready;
    assign w_dataDone  = (r_state == c_ISSUE_D) && mem_ready;

    // A flush arriving on the completing cycle squashes the result as well.
    assign w_squashFetch = r_kill | if_flush;

    // ------------------------------------------------------------------
    // Starvation counter and fetch kill flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starveCnt <= 4'd0;
            r_kill      <= 1'b0;
        end else begin
            if (w_grantI) begin
                r_starveCnt <= 4'd0;
            end else if (w_grantD) begin
                if (!if_req) begin
                    r_starveCnt <= 4'd0;
                end else if (r_starveCnt < c_STARVE_LIMIT) begin
                    r_starveCnt <= r_starveCnt + 4'd1;
                end
            end

            if (r_state == c_RESP_I) begin
                r_kill <= 1'b0;
            end else if ((r_state == c_ISSUE_I) && if_flush) begin
                r_kill <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Port request and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_memReq   <= 1'b0;
            r_memWe    <= 1'b0;
            r_memSize  <= 2'b00;
            r_memAddr  <= '0;
            r_memWdata <= 64'd0;
            r_ifRdata  <= 32'd0;
            r_dRdata   <= 64'd0;
            r_ifValid  <= 1'b0;
            r_dValid   <= 1'b0;
        end else begin
            // Valid flags are single-cycle pulses.
            r_ifValid <= 1'b0;
            r_dValid  <= 1'b0;

            if (w_grantD) begin
                r_memReq   <= 1'b1;
                r_memWe    <= d_we;
                r_memSize  <= d_size;
                r_memAddr  <= d_addr;
                r_memWdata <= d_wdata;
            end else if (w_grantI) begin
                r_memReq   <= 1'b1;
                r_memWe    <= 1'b0;
                r_memSize  <= c_SIZE_WORD;
                r_memAddr  <= if_addr;
                r_memWdata <= 64'd0;
            end else if (w_fetchDone || w_dataDone) begin
                r_memReq <= 1'b0;
            end

            if (w_fetchDone && !w_squashFetch) begin
                r_ifRdata <= mem_rdata[31:0];
                r_ifValid <= 1'b1;
            end

            // The latched write enable decides load vs store, so the
            // requester's fields are not needed once the access is issued.
            if (w_dataDone) begin
                r_dRdata <= r_memWe ? 64'd0 : mem_rdata;
                r_dValid <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs. A flush in the response cycle still hides the pulse.
    // ------------------------------------------------------------------
    assign mem_req   = r_memReq;
    assign mem_we    = r_memWe;
    assign mem_size  = r_memSize;
    assign mem_addr  = r_memAddr;
    assign mem_wdata = r_memWdata;

    assign if_rdata  = r_ifRdata;
    assign if_valid  = r_ifValid & ~if_flush;
    assign d_rdata   = r_dRdata;
    assign d_valid   = r_dValid;

    assign if_stall  = if_req & ~if_valid;
    assign d_stall   = d_req & ~d_valid;

endmodule
`default_nettype wire
